// File: rtl/fwd_pkg.sv
// fwd_pkg: shared definitions for the forwarding / load-use hazard unit.
//   FW_NOP        select value that routes register-file data to the consumer
//   fw_stage_sel  maps forwarding source stage k to its bypass-mux select
//   hz_state_e    load-use FSM states (IDLE: no pending load, HOLD: counting down)
package fwd_pkg;

  localparam int FW_NOP = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } hz_state_e;

  // Stage k (0 = youngest) is reached through mux input k+1.
  function automatic int fw_stage_sel(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/fwd_sel_node.sv
// fwd_sel_node: forwarding select for a single read port.
// Compares one source register number against every writeback stage and
// returns the select of the youngest matching writer, or FW_NOP.
//   rn_i     source register number
//   vld_i    port actually reads rn_i
//   st_we_i  stage k will write back
//   st_rn_i  stage k destination, stage k at [k*RN_W +: RN_W]
//   sel_o    bypass-mux select (FW_NOP or k+1)
module fwd_sel_node
  import fwd_pkg::*;
#(
  parameter int NSTG  = 2,
  parameter int RN_W  = 5,
  parameter int SEL_W = 2
) (
  input  logic [RN_W-1:0]      rn_i,
  input  logic                 vld_i,
  input  logic [NSTG-1:0]      st_we_i,
  input  logic [NSTG*RN_W-1:0] st_rn_i,
  output logic [SEL_W-1:0]     sel_o
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    sel_o = SEL_W'(FW_NOP);
    // Walk from oldest to youngest so the youngest match is written last
    // and wins. Register 0 is hard-wired and never forwarded.
    for (int k = NSTG - 1; k >= 0; k--) begin
      if (vld_i && (rn_i != '0) && st_we_i[k] &&
          (st_rn_i[k*RN_W +: RN_W] == rn_i)) begin
        sel_o = SEL_W'(fw_stage_sel(k));
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding and load-use hazard control.
//   clk, rst        clock; synchronous active-low reset
//   pause           global pipeline freeze
//   flush           squash ID->EX (branch / exception)
//   rd_rn_i/vld_i   decode-stage source registers and their read enables
//   st_we_i/rn_i    writeback stages (0 = youngest) and their destinations
//   st_ld_i         stage holds a load whose data is not yet forwardable
//   id_fw_o         combinational decode-stage bypass selects
//   ex_fw_o         EX-stage bypass selects from the registered sources
//   stall_o         hold PC and IF/ID
//   bubble_o        insert a NOP into ID->EX this cycle
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NRD    = 2,
  parameter int NSTG   = 2,
  parameter int RN_W   = 5,
  parameter int LD_LAT = 1,
  parameter int SEL_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pause,
  input  logic                 flush,
  input  logic [NRD*RN_W-1:0]  rd_rn_i,
  input  logic [NRD-1:0]       rd_vld_i,
  input  logic [NSTG-1:0]      st_we_i,
  input  logic [NSTG*RN_W-1:0] st_rn_i,
  input  logic [NSTG-1:0]      st_ld_i,
  output logic [NRD*SEL_W-1:0] id_fw_o,
  output logic [NRD*SEL_W-1:0] ex_fw_o,
  output logic                 stall_o,
  output logic                 bubble_o
);

  if ((2 ** SEL_W) < (NSTG + 1)) begin : g_bad_sel_w
    $error("fwd_hazard_unit: SEL_W too narrow for NSTG stages plus FW_NOP");
  end
  if (LD_LAT > 7) begin : g_bad_ld_lat
    $error("fwd_hazard_unit: LD_LAT must be 0..7");
  end

  localparam bit       LD_EN    = (LD_LAT > 0);
  // HOLD covers LD_LAT cycles after the detecting cycle, so it starts at LD_LAT-1.
  localparam logic [2:0] CNT_INIT = LD_EN ? 3'(LD_LAT - 1) : 3'd0;

  hz_state_e           state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [NRD*RN_W-1:0] ex_rn_q, ex_rn_d;
  logic [NRD-1:0]      ex_vld_q, ex_vld_d;
  logic                ld_hit0, ld_late;

  for (genvar p = 0; p < NRD; p++) begin : g_port
    fwd_sel_node #(.NSTG(NSTG), .RN_W(RN_W), .SEL_W(SEL_W)) u_id_sel (
      .rn_i    (rd_rn_i[p*RN_W +: RN_W]),
      .vld_i   (rd_vld_i[p]),
      .st_we_i (st_we_i),
      .st_rn_i (st_rn_i),
      .sel_o   (id_fw_o[p*SEL_W +: SEL_W])
    );
    fwd_sel_node #(.NSTG(NSTG), .RN_W(RN_W), .SEL_W(SEL_W)) u_ex_sel (
      .rn_i    (ex_rn_q[p*RN_W +: RN_W]),
      .vld_i   (ex_vld_q[p]),
      .st_we_i (st_we_i),
      .st_rn_i (st_rn_i),
      .sel_o   (ex_fw_o[p*SEL_W +: SEL_W])
    );
  end

  // A consumer reading a pending load: at stage 0 this starts the timed
  // hold; at an older stage it simply stalls until that stage drops st_ld.
  always_comb begin
    ld_hit0 = 1'b0;
    ld_late = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      for (int k = 0; k < NSTG; k++) begin
        if (rd_vld_i[p] && (rd_rn_i[p*RN_W +: RN_W] != '0) && st_we_i[k] &&
            st_ld_i[k] && (st_rn_i[k*RN_W +: RN_W] == rd_rn_i[p*RN_W +: RN_W])) begin
          if (k == 0) ld_hit0 = 1'b1;
          else        ld_late = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (LD_EN && ld_hit0 && !pause && !flush) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_INIT;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else if (!pause) begin
          if (cnt_q == 3'd0) state_d = ST_IDLE;
          else               cnt_d   = cnt_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A flushed instruction is discarded anyway, so it never needs a stall.
    stall_o  = ((state_q == ST_IDLE) && LD_EN && ld_hit0 ||
                (state_q == ST_HOLD) || ld_late) && !flush;
    bubble_o = stall_o && !pause;

    ex_rn_d  = ex_rn_q;
    ex_vld_d = ex_vld_q;
    if (flush || (bubble_o && !pause)) begin
      ex_rn_d  = '0;
      ex_vld_d = '0;
    end else if (!pause) begin
      ex_rn_d  = rd_rn_i;
      ex_vld_d = rd_vld_i;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge like any other input, and all
    // state updates use non-blocking assignments so every flop sees the
    // pre-edge values of the others.
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      ex_rn_q  <= '0;
      ex_vld_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ex_rn_q  <= ex_rn_d;
      ex_vld_q <= ex_vld_d;
    end
  end

endmodule
